// File: rtl/mmio_out_port.sv
// mmio_out_port: memory-mapped byte output port with FIFO and drain handshake.
// Optional overflow counter enabled by defining MMIO_OUT_OVF_COUNT_EN.
//
// Ports:
//   clk, rst             clock, async active-high reset
//   write, addr, wdata   cpu bus write strobe, address, write data
//   rdata, sel           combinational read data, window hit
//   out_data, out_valid  FIFO head and valid toward the consumer
//   out_ready            consumer accepts out_data this cycle
//
// Register window (4 addresses from BASE_ADDR):
//   +0 DATA    write pushes, read peeks head (0 if empty)
//   +1 STATUS  {count, full, empty}
//   +2 OVF     saturating drop counter, any write clears
//   +3 CTRL    bit0 drain_en, bit1 flush (write-only)
module mmio_out_port #(
  parameter int addr_width = 8,
  parameter int data_width = 8,
  parameter logic [addr_width-1:0] BASE_ADDR = addr_width'(8'hFC),
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write,
  input  logic [addr_width-1:0] addr,
  input  logic [data_width-1:0] wdata,
  output logic [data_width-1:0] rdata,
  output logic                  sel,
  output logic [data_width-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [data_width-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          drain_en;
  logic [data_width-1:0] ovf;

  logic [1:0] off;
  logic empty;
  logic full;
  logic push_req;
  logic push_ok;
  logic pop;
  logic ctrl_wr;
  logic flush;
  logic [data_width-1:0] head;
  logic [data_width-1:0] cnt_w;

  assign sel = (addr[addr_width-1:2] == BASE_ADDR[addr_width-1:2]);
  assign off = addr[1:0];

  assign empty = (count == '0);
  assign full  = (count == CW'(FIFO_DEPTH));
  assign head  = empty ? '0 : mem[rd_ptr];

  assign out_valid = drain_en && !empty;
  assign out_data  = head;

  assign push_req = write && sel && (off == 2'd0);
  assign ctrl_wr  = write && sel && (off == 2'd3);
  assign flush    = ctrl_wr && wdata[1];
  assign pop      = out_valid && out_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok  = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      drain_en <= 1'b1;
    end else begin
      if (ctrl_wr) begin
        drain_en <= wdata[0];
      end
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        if (push_ok && !pop) begin
          count <= count + CW'(1);
        end else if (pop && !push_ok) begin
          count <= count - CW'(1);
        end
      end
    end
  end

`ifdef MMIO_OUT_OVF_COUNT_EN
  logic drop;
  logic ovf_wr;

  assign drop   = push_req && full && !pop;
  assign ovf_wr = write && sel && (off == 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= '0;
    end else if (ovf_wr) begin
      ovf <= '0;
    end else if (drop && (ovf != '1)) begin
      ovf <= ovf + data_width'(1);
    end
  end
`else
  assign ovf = '0;
`endif

  assign cnt_w = data_width'(count);

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (off)
        2'd0: rdata = head;
        2'd1: rdata = {cnt_w[data_width-3:0], full, empty};
        2'd2: rdata = ovf;
        2'd3: rdata = {{(data_width-1){1'b0}}, drain_en};
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_out_port.sv
// tb_mmio_out_port: directed steps with a queue scoreboard on the drain side.
// Expected OVF values depend on MMIO_OUT_OVF_COUNT_EN.
module tb_mmio_out_port;

  logic       clk;
  logic       rst;
  logic       write;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       sel;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  int checks;
  int passed;
  int fails;

  logic [7:0] q[$];
  logic       m_drain;

  mmio_out_port dut (
    .clk(clk),
    .rst(rst),
    .write(write),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .sel(sel),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Inputs change at posedge+1; each task returns at posedge+1.
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr  = a;
    wdata = d;
    write = 1'b1;
    @(posedge clk);
    #1 write = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a,
                    input logic [7:0] exp);
    addr = a;
    @(negedge clk);
    chk(tag, rdata, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model of the drain side, evaluated between edges.
  always @(negedge clk) begin
    logic exp_v;
    logic pop;
    logic full;
    logic push;
    if (rst) begin
      q.delete();
      m_drain = 1'b1;
    end else begin
      exp_v = m_drain && (q.size() != 0);
      chk("out_valid", {7'd0, out_valid}, {7'd0, exp_v});
      if (exp_v) chk("out_data", out_data, q[0]);
      full = (q.size() == 4);
      pop  = exp_v && out_ready;
      push = write && (addr == 8'hFC);
      if (pop) void'(q.pop_front());
      if (write && addr == 8'hFF) m_drain = wdata[0];
      if (write && addr == 8'hFF && wdata[1]) q.delete();
      else if (push && (!full || pop)) q.push_back(wdata);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks    = 0;
    passed    = 0;
    fails     = 0;
    m_drain   = 1'b1;
    rst       = 1'b1;
    write     = 1'b0;
    addr      = 8'hFD;
    wdata     = 8'h00;
    out_ready = 1'b0;

    @(negedge clk);
    chk("rst_valid", {7'd0, out_valid}, 8'h00);
    chk("rst_data", out_data, 8'h00);
    chk("rst_status", rdata, 8'h01);
    cyc(2);
    rst = 1'b0;
    cyc(1);

    rd("status0", 8'hFD, 8'h01);
    rd("ctrl0", 8'hFF, 8'h01);
    rd("off_win", 8'h7C, 8'h00);
    chk("sel_off", {7'd0, sel}, 8'h00);
    rd("sel_lo", 8'h00, 8'h00);

    wr(8'hFC, 8'hA1);
    wr(8'hFC, 8'hA2);
    wr(8'h00, 8'h77);
    wr(8'hFD, 8'hFF);
    rd("status2", 8'hFD, 8'h08);
    chk("head_a1", out_data, 8'hA1);
    chk("sel_on", {7'd0, sel}, 8'h01);
    rd("peek", 8'hFC, 8'hA1);
    rd("status2b", 8'hFD, 8'h08);

    out_ready = 1'b1;
    cyc(2);
    out_ready = 1'b0;
    rd("drained", 8'hFD, 8'h01);
    rd("peek_empty", 8'hFC, 8'h00);

    for (int i = 0; i < 6; i++) wr(8'hFC, 8'h10 + 8'(i));
    rd("full", 8'hFD, 8'h12);
`ifdef MMIO_OUT_OVF_COUNT_EN
    rd("ovf2", 8'hFE, 8'h02);
    for (int i = 0; i < 260; i++) wr(8'hFC, 8'hEE);
    rd("ovf_sat", 8'hFE, 8'hFF);
`else
    rd("ovf_off", 8'hFE, 8'h00);
`endif
    wr(8'hFE, 8'h00);
    rd("ovf_clr", 8'hFE, 8'h00);

    addr      = 8'hFC;
    wdata     = 8'h55;
    write     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    write     = 1'b0;
    out_ready = 1'b0;
    rd("full_pp", 8'hFD, 8'h12);
    rd("ovf_keep", 8'hFE, 8'h00);
    chk("head_11", out_data, 8'h11);
    out_ready = 1'b1;
    cyc(4);
    out_ready = 1'b0;
    rd("wrap_empty", 8'hFD, 8'h01);

    wr(8'hFC, 8'h20);
    wr(8'hFC, 8'h21);
    wr(8'hFC, 8'h22);
    wr(8'hFF, 8'h00);
    out_ready = 1'b1;
    cyc(2);
    chk("hold_valid", {7'd0, out_valid}, 8'h00);
    rd("hold_cnt", 8'hFD, 8'h0C);
    rd("ctrl_off", 8'hFF, 8'h00);
    wr(8'hFF, 8'h03);
    rd("flush_cnt", 8'hFD, 8'h01);
    chk("flush_valid", {7'd0, out_valid}, 8'h00);
    rd("flush_ctrl", 8'hFF, 8'h01);
    out_ready = 1'b0;

    wr(8'hFC, 8'h40);
    wr(8'hFC, 8'h41);
    out_ready = 1'b1;
    wr(8'hFF, 8'h03);
    out_ready = 1'b0;
    rd("flush_pop", 8'hFD, 8'h01);

    wr(8'hFC, 8'h30);
    wr(8'hFC, 8'h31);
    wr(8'hFC, 8'h32);
    out_ready = 1'b1;
    cyc(1);
    chk("mid_valid", {7'd0, out_valid}, 8'h01);
    chk("mid_head", out_data, 8'h31);
    rst = 1'b1;
    #1;
    chk("async_valid", {7'd0, out_valid}, 8'h00);
    chk("async_data", out_data, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b0;
    rd("post_rst", 8'hFD, 8'h01);
    rd("post_ctrl", 8'hFF, 8'h01);

    for (int i = 0; i < 5; i++) wr(8'hFC, 8'h60 + 8'(i));
`ifdef MMIO_OUT_OVF_COUNT_EN
    rd("ovf1", 8'hFE, 8'h01);
`else
    rd("ovf_none", 8'hFE, 8'h00);
`endif
    out_ready = 1'b1;
    cyc(5);
    out_ready = 1'b0;
    rd("final", 8'hFD, 8'h01);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
